// File: rtl/pes_ptvm_ctrl_if.sv
// Coin/mechanism bus of the ticket vending controller.
// The controller takes the slave side: it receives the coin strobe, the user
// cancel and the two mechanism acks, and drives the requests and status.
interface pes_ptvm_ctrl_if #(
    parameter int CREDIT_W = 3
);
    logic                coin_vld;
    logic [1:0]          coin_val;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ack;
    logic                disp_req;
    logic                chg_req;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_rej;
    logic                vend_done;

    // Controller side
    modport slave (
        input  coin_vld, coin_val, cancel, disp_ack, chg_ack,
        output disp_req, chg_req, credit, busy, coin_rej, vend_done
    );

    // Coin acceptor / mechanism driver side
    modport master (
        output coin_vld, coin_val, cancel, disp_ack, chg_ack,
        input  disp_req, chg_req, credit, busy, coin_rej, vend_done
    );
endinterface

// File: rtl/pes_ptvm_ctrl.sv
// Ticket vending transaction controller.
// Accumulates coin credit up to PRICE, then runs the dispenser handshake and
// returns any remaining credit one unit per change-unit ack. A cancel while
// collecting refunds the whole credit without issuing a ticket.
// Optional feature: define VEND_TIMEOUT_EN to refund automatically after
// TIMEOUT_CYC idle cycles in the collecting state.
// All outputs come straight from registers; reset is asynchronous, active low.
module pes_ptvm_ctrl #(
    parameter int PRICE       = 3,
    parameter int CREDIT_W    = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    pes_ptvm_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    // Elaboration-time parameter sanity: credit must hold PRICE+1 and the
    // timer must be able to reach TIMEOUT_CYC-1.
    if (PRICE < 1) begin : g_bad_price
        $error("pes_ptvm_ctrl: PRICE must be at least 1");
    end
    if ((PRICE + 1) > ((1 << CREDIT_W) - 1)) begin : g_bad_credit_w
        $error("pes_ptvm_ctrl: CREDIT_W too small to hold PRICE+1");
    end
    if ((TIMEOUT_CYC < 2) || ((TIMEOUT_CYC - 1) > ((1 << TMR_W) - 1))) begin : g_bad_tmr_w
        $error("pes_ptvm_ctrl: TMR_W cannot hold TIMEOUT_CYC-1");
    end

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_vend;        // 1 once a ticket was issued in this transaction
    logic                r_disp_req;
    logic                r_chg_req;
    logic                r_busy;
    logic                r_coin_rej;
    logic                r_vend_done;

    logic [CREDIT_W-1:0] w_coin_units;
    logic                w_coin_ok;
    logic                w_coin_in;
    logic [CREDIT_W-1:0] w_sum;
    logic [CREDIT_W-1:0] w_credit_new;
    logic                w_timeout;
    logic                w_refund;

    // Decode the coin value; only 1- and 2-unit coins are legal
    always_comb begin
        w_coin_units = '0;
        w_coin_ok    = 1'b0;
        case (bus.coin_val)
            2'b01: begin
                w_coin_units = CREDIT_W'(1);
                w_coin_ok    = 1'b1;
            end
            2'b10: begin
                w_coin_units = CREDIT_W'(2);
                w_coin_ok    = 1'b1;
            end
            default: begin
                w_coin_units = '0;
                w_coin_ok    = 1'b0;
            end
        endcase
    end

    assign w_coin_in    = bus.coin_vld & w_coin_ok;
    assign w_sum        = r_credit + w_coin_units;
    // A coin landing together with a refund decision is credited first
    assign w_credit_new = w_coin_in ? w_sum : r_credit;

`ifdef VEND_TIMEOUT_EN
    logic [TMR_W-1:0] r_timer;

    assign w_timeout = (r_state == COLLECT) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Idle timer: counts cycles spent in COLLECT, restarts on every accepted
    // coin and whenever COLLECT is left (cancel or timeout refund included)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if ((r_state == COLLECT) && !w_coin_in && !bus.cancel && !w_timeout) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end
`else
    // Without the timeout option COLLECT waits for coins or cancel forever
    assign w_timeout = 1'b0;
`endif

    // Leaving COLLECT as a refund: cancel always wins, the timeout only when
    // no coin arrives in the same cycle (a coin restarts the idle period)
    assign w_refund = (r_state == COLLECT) && (bus.cancel || (w_timeout && !w_coin_in));

    // Transaction FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_vend      <= 1'b0;
            r_disp_req  <= 1'b0;
            r_chg_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_vend_done <= 1'b0;
        end else begin
            r_coin_rej  <= 1'b0;
            r_vend_done <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    if (bus.coin_vld && !w_coin_ok) begin
                        r_coin_rej <= 1'b1;
                    end
                    if (w_refund) begin
                        r_credit  <= w_credit_new;
                        r_vend    <= 1'b0;
                        r_chg_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= CHANGE;
                    end else if (w_coin_in) begin
                        r_credit <= w_sum;
                        if (w_sum >= PRICE_C) begin
                            r_disp_req <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= DISPENSE;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end

                DISPENSE: begin
                    // Mechanism busy: every coin bounces, cancel has no effect
                    r_coin_rej <= bus.coin_vld;
                    if (bus.disp_ack) begin
                        r_disp_req <= 1'b0;
                        r_credit   <= r_credit - PRICE_C;
                        r_vend     <= 1'b1;
                        if (r_credit != PRICE_C) begin
                            r_chg_req <= 1'b1;
                            r_state   <= CHANGE;
                        end else begin
                            r_busy      <= 1'b0;
                            r_vend_done <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end

                CHANGE: begin
                    r_coin_rej <= bus.coin_vld;
                    if (bus.chg_ack) begin
                        r_credit <= r_credit - ONE_C;
                        // Last unit returned: transaction complete
                        if (r_credit == ONE_C) begin
                            r_chg_req   <= 1'b0;
                            r_busy      <= 1'b0;
                            r_vend_done <= r_vend;
                            r_state     <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.disp_req  = r_disp_req;
    assign bus.chg_req   = r_chg_req;
    assign bus.credit    = r_credit;
    assign bus.busy      = r_busy;
    assign bus.coin_rej  = r_coin_rej;
    assign bus.vend_done = r_vend_done;

endmodule
